// File: rtl/output_align_pkg.sv
// Shared constants for the load-return aligner: size codes, size masks,
// FSM encoding and line geometry.
package output_align_pkg;

   localparam int LINE_BYTES = 16;
   localparam int OFF_W      = $clog2(LINE_BYTES);
   localparam int LINE_W     = LINE_BYTES * 8;
   localparam int DATA_W     = 64;

   localparam logic [1:0] SZ_1B = 2'b00;
   localparam logic [1:0] SZ_2B = 2'b01;
   localparam logic [1:0] SZ_4B = 2'b10;
   localparam logic [1:0] SZ_8B = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_OUT  = 2'd2;

   function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] sz);
      logic [DATA_W-1:0] m;
      case (sz)
         SZ_1B:   m = 64'h0000_0000_0000_00FF;
         SZ_2B:   m = 64'h0000_0000_0000_FFFF;
         SZ_4B:   m = 64'h0000_0000_FFFF_FFFF;
         default: m = '1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/output_align_if.sv
// Descriptor, cache-response and writeback-result signals of the aligner.
// master drives descriptors/responses; slave is the aligner itself.
interface output_align_if;
   import output_align_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic [OFF_W-1:0]  req_offset;
   logic [1:0]        req_size;
   logic              req_needP1;
   logic              req_ptc_id;
   logic              resp0_valid;
   logic [LINE_W-1:0] resp0_data;
   logic              resp1_valid;
   logic [LINE_W-1:0] resp1_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_ptc_id;
   logic              stray_err;

   modport master (
      output req_valid, req_offset, req_size, req_needP1, req_ptc_id,
      output resp0_valid, resp0_data, resp1_valid, resp1_data, out_ready,
      input  req_ready, out_valid, out_data, out_ptc_id, stray_err
   );

   modport slave (
      input  req_valid, req_offset, req_size, req_needP1, req_ptc_id,
      input  resp0_valid, resp0_data, resp1_valid, resp1_data, out_ready,
      output req_ready, out_valid, out_data, out_ptc_id, stray_err
   );

endinterface

// File: rtl/output_align_rd_align_shifter.sv
// Combinational byte shifter: moves byte 'offset' of the merged two-line word
// down to bit 0 through 1/2/4/8-byte stages, then masks to the access size.
module rd_align_shifter
   import output_align_pkg::*;
(
   input  logic [2*LINE_W-1:0] merged,
   input  logic [OFF_W-1:0]    offset,
   input  logic [1:0]          size,
   output logic [DATA_W-1:0]   result
);

   logic [OFF_W:0][2*LINE_W-1:0] stage;

   assign stage[0] = merged;

   for (genvar gi = 0; gi < OFF_W; gi++) begin : g_stage
      assign stage[gi+1] = offset[gi] ? (stage[gi] >> (8 << gi)) : stage[gi];
   end

   assign result = stage[OFF_W][DATA_W-1:0] & size_mask(size);

   // Bytes above the result never reach the output.
   logic unused_hi;
   assign unused_hi = ^stage[OFF_W][2*LINE_W-1:DATA_W];

endmodule

// File: rtl/output_align.sv
// Collects one or two cache-line responses for a single outstanding load,
// merges and aligns them, and hands one result to writeback.
module output_align
   import output_align_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   output_align_if.slave  bus
);

   logic [1:0]        state_reg;
   logic [OFF_W-1:0]  offset_reg;
   logic [1:0]        size_reg;
   logic              needp1_reg;
   logic              ptc_reg;
   logic              got0_reg, got1_reg;
   logic [LINE_W-1:0] line0_reg, line1_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic              out_ptc_reg;
   logic              stray_reg;

   logic              in_wait;
   logic              cap0, cap1, done, stray_next;
   logic [LINE_W-1:0] line0_cur, line1_cur;
   logic [DATA_W-1:0] aligned;

   assign in_wait = (state_reg == ST_WAIT);
   assign cap0    = in_wait && bus.resp0_valid && !got0_reg;
   assign cap1    = in_wait && bus.resp1_valid && !got1_reg && needp1_reg;
   assign done    = in_wait && (got0_reg || cap0) && (got1_reg || cap1 || !needp1_reg);

   // Any response not consumed as a capture is stray, whatever the state.
   assign stray_next = (bus.resp0_valid && !cap0) || (bus.resp1_valid && !cap1);

   // Same-cycle captures bypass the registers so completion costs no extra cycle.
   assign line0_cur = cap0 ? bus.resp0_data : line0_reg;
   assign line1_cur = cap1 ? bus.resp1_data : line1_reg;

   rd_align_shifter u_shifter (
      .merged ({(needp1_reg ? line1_cur : {LINE_W{1'b0}}), line0_cur}),
      .offset (offset_reg),
      .size   (size_reg),
      .result (aligned)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         offset_reg   <= '0;
         size_reg     <= '0;
         needp1_reg   <= 1'b0;
         ptc_reg      <= 1'b0;
         got0_reg     <= 1'b0;
         got1_reg     <= 1'b0;
         line0_reg    <= '0;
         line1_reg    <= '0;
         out_data_reg <= '0;
         out_ptc_reg  <= 1'b0;
         stray_reg    <= 1'b0;
      end else begin
         stray_reg <= stray_next;
         case (state_reg)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  offset_reg <= bus.req_offset;
                  size_reg   <= bus.req_size;
                  needp1_reg <= bus.req_needP1;
                  ptc_reg    <= bus.req_ptc_id;
                  got0_reg   <= 1'b0;
                  got1_reg   <= 1'b0;
                  state_reg  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cap0) begin
                  line0_reg <= bus.resp0_data;
                  got0_reg  <= 1'b1;
               end
               if (cap1) begin
                  line1_reg <= bus.resp1_data;
                  got1_reg  <= 1'b1;
               end
               if (done) begin
                  out_data_reg <= aligned;
                  out_ptc_reg  <= ptc_reg;
                  state_reg    <= ST_OUT;
               end
            end
            ST_OUT: begin
               if (bus.out_ready) state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state_reg == ST_IDLE);
   assign bus.out_valid  = (state_reg == ST_OUT);
   assign bus.out_data   = out_data_reg;
   assign bus.out_ptc_id = out_ptc_reg;
   assign bus.stray_err  = stray_reg;

endmodule

// File: tb/tb_output_align.sv
// Directed bench for output_align: expected results are queued at descriptor
// issue and compared when the aligned result appears.
module tb_output_align;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   int   stray_cnt = 0;
   int   hs_cnt = 0;
   logic [64:0] exp_q[$];

   output_align_if bus ();

   output_align dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.stray_err === 1'b1) stray_cnt++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) hs_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Byte-by-byte reference: walk the access bytes across the two lines.
   function automatic logic [63:0] model(input logic [3:0] off, input logic [1:0] sz,
                                         input logic np, input logic [127:0] l0,
                                         input logic [127:0] l1);
      logic [63:0] r;
      int idx;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         if (k < (1 << sz)) begin
            idx = int'(off) + k;
            if (idx < 16)  r[k*8 +: 8] = l0[idx*8 +: 8];
            else if (np)   r[k*8 +: 8] = l1[(idx-16)*8 +: 8];
            else           r[k*8 +: 8] = 8'h00;
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic issue(input logic [3:0] off, input logic [1:0] sz, input logic np,
                        input logic ptc, input logic [127:0] l0, input logic [127:0] l1);
      check("req_ready_before_issue", bus.req_ready, 1);
      bus.req_valid  = 1'b1;
      bus.req_offset = off;
      bus.req_size   = sz;
      bus.req_needP1 = np;
      bus.req_ptc_id = ptc;
      step();
      bus.req_valid = 1'b0;
      exp_q.push_back({ptc, model(off, sz, np, l0, l1)});
   endtask

   task automatic compare_out(input string tag);
      logic [64:0] e;
      check({tag, "_out_valid"}, bus.out_valid, 1);
      if (exp_q.size() == 0) begin
         check({tag, "_queue_nonempty"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_out_data"}, bus.out_data, e[63:0]);
         check({tag, "_out_ptc_id"}, bus.out_ptc_id, e[64]);
      end
   endtask

   // order: 0 = resp0 then resp1, 1 = resp1 then resp0, 2 = same cycle
   task automatic do_access(input string tag, input logic [3:0] off, input logic [1:0] sz,
                            input logic np, input logic ptc, input logic [127:0] l0,
                            input logic [127:0] l1, input int order);
      issue(off, sz, np, ptc, l0, l1);
      bus.resp0_data = l0;
      bus.resp1_data = l1;
      if (np && order == 2) begin
         bus.resp0_valid = 1'b1;
         bus.resp1_valid = 1'b1;
         step();
         bus.resp0_valid = 1'b0;
         bus.resp1_valid = 1'b0;
      end else if (np && order == 1) begin
         bus.resp1_valid = 1'b1;
         step();
         bus.resp1_valid = 1'b0;
         check({tag, "_early_valid"}, bus.out_valid, 0);
         bus.resp0_valid = 1'b1;
         step();
         bus.resp0_valid = 1'b0;
      end else begin
         bus.resp0_valid = 1'b1;
         step();
         bus.resp0_valid = 1'b0;
         if (np) begin
            check({tag, "_early_valid"}, bus.out_valid, 0);
            bus.resp1_valid = 1'b1;
            step();
            bus.resp1_valid = 1'b0;
         end
      end
      compare_out(tag);
   endtask

   task automatic finish_out(input string tag);
      step();
      check({tag, "_valid_after_hs"}, bus.out_valid, 0);
      check({tag, "_ready_after_hs"}, bus.req_ready, 1);
   endtask

   initial begin
      logic [127:0] inc0, inc1, la, lb;
      logic [63:0]  held;
      int s0, h0;

      for (int i = 0; i < 16; i++) begin
         inc0[i*8 +: 8] = 8'(i);
         inc1[i*8 +: 8] = 8'(8'h10 + i);
      end
      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_offset = '0; bus.req_size = '0;
      bus.req_needP1 = 1'b0; bus.req_ptc_id = 1'b0;
      bus.resp0_valid = 1'b0; bus.resp0_data = '0;
      bus.resp1_valid = 1'b0; bus.resp1_data = '0;
      bus.out_ready = 1'b1;
      #1;
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_ptc_id", bus.out_ptc_id, 0);
      check("rst_stray_err", bus.stray_err, 0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // Single line, 4 bytes at offset 3
      s0 = stray_cnt;
      do_access("aligned", 4'h3, 2'b10, 1'b0, 1'b0, inc0, inc1, 0);
      check("aligned_const", bus.out_data, 64'h0000_0000_0605_0403);
      finish_out("aligned");
      check("aligned_no_stray", stray_cnt - s0, 0);

      // Line crossing, in order / reversed / same cycle
      do_access("cross_fwd", 4'hE, 2'b11, 1'b1, 1'b1, inc0, inc1, 0);
      check("cross_fwd_const", bus.out_data, 64'h1514_1312_1110_0F0E);
      finish_out("cross_fwd");
      do_access("cross_rev", 4'hE, 2'b11, 1'b1, 1'b0, inc0, inc1, 1);
      check("cross_rev_const", bus.out_data, 64'h1514_1312_1110_0F0E);
      finish_out("cross_rev");
      do_access("cross_same", 4'hE, 2'b11, 1'b1, 1'b1, inc0, inc1, 2);
      check("cross_same_const", bus.out_data, 64'h1514_1312_1110_0F0E);
      finish_out("cross_same");

      // Backpressure: result must hold and no new descriptor accepted
      bus.out_ready = 1'b0;
      do_access("bp", 4'hB, 2'b11, 1'b1, 1'b1, rand_line(), rand_line(), 0);
      held = bus.out_data;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_valid_hold", bus.out_valid, 1);
         check("bp_data_hold", bus.out_data, held);
         check("bp_req_ready", bus.req_ready, 0);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_req_ready_hs_cycle", bus.req_ready, 0);
      finish_out("bp");

      // Stray resp0 in IDLE
      s0 = stray_cnt;
      h0 = hs_cnt;
      bus.resp0_valid = 1'b1;
      step();
      bus.resp0_valid = 1'b0;
      check("idle_stray_pulse", bus.stray_err, 1);
      step();
      check("idle_stray_clear", bus.stray_err, 0);
      check("idle_stray_count", stray_cnt - s0, 1);
      check("idle_no_output", hs_cnt - h0, 0);

      // resp1 while needP1=0: stray, result uses line0 only
      la = rand_line();
      lb = rand_line();
      s0 = stray_cnt;
      issue(4'h9, 2'b11, 1'b0, 1'b1, la, lb);
      bus.resp1_data = lb;
      bus.resp1_valid = 1'b1;
      step();
      bus.resp1_valid = 1'b0;
      check("np0_resp1_no_valid", bus.out_valid, 0);
      bus.resp0_data = la;
      bus.resp0_valid = 1'b1;
      step();
      bus.resp0_valid = 1'b0;
      compare_out("np0_resp1");
      finish_out("np0_resp1");
      check("np0_resp1_stray", stray_cnt - s0, 1);

      // Duplicate resp0: first data kept
      la = rand_line();
      lb = rand_line();
      s0 = stray_cnt;
      issue(4'hD, 2'b10, 1'b1, 1'b0, la, lb);
      bus.resp0_data = la;
      bus.resp0_valid = 1'b1;
      step();
      bus.resp0_data = ~la;
      step();
      bus.resp0_valid = 1'b0;
      check("dup_no_valid", bus.out_valid, 0);
      bus.resp1_data = lb;
      bus.resp1_valid = 1'b1;
      step();
      bus.resp1_valid = 1'b0;
      compare_out("dup");
      finish_out("dup");
      check("dup_stray", stray_cnt - s0, 1);

      // Random accesses against the byte model
      for (int i = 0; i < 8; i++) begin
         logic [3:0] off;
         logic [1:0] sz;
         logic np;
         off = 4'($urandom_range(0, 15));
         sz  = 2'($urandom_range(0, 3));
         np  = ((int'(off) + (1 << sz)) > 16) ? 1'b1 : 1'($urandom_range(0, 1));
         do_access("rand", off, sz, np, 1'($urandom_range(0, 1)), rand_line(), rand_line(),
                   int'($urandom_range(0, 2)));
         finish_out("rand");
      end

      // Reset while waiting for line 1
      s0 = stray_cnt;
      h0 = hs_cnt;
      issue(4'hC, 2'b11, 1'b1, 1'b1, inc0, inc1);
      void'(exp_q.pop_back());
      bus.resp0_data = inc0;
      bus.resp0_valid = 1'b1;
      step();
      bus.resp0_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_req_ready", bus.req_ready, 1);
      check("midrst_out_valid", bus.out_valid, 0);
      step();
      step();
      rst_n = 1'b1;
      bus.resp1_data = inc1;
      bus.resp1_valid = 1'b1;
      step();
      bus.resp1_valid = 1'b0;
      check("midrst_stray_pulse", bus.stray_err, 1);
      step();
      step();
      check("midrst_stray_count", stray_cnt - s0, 1);
      check("midrst_no_output", hs_cnt - h0, 0);
      check("midrst_ready", bus.req_ready, 1);
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
